// File: rtl/pp_buffer_scheduler.sv
// Purpose : ping-pong scheduler for two 1-bit x BLOCK_LEN RAM banks between a bit source and a block consumer.
// Latency : block readable the cycle after its last bit is written; first rd_en one cycle later; q valid the next cycle.
// Backpress: in_ready drops while the bank being written is still full; reads stall while out_valid && !out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream bit handshake
//   wr_en_a/b, wr_addr    RAM write controls (address shared by both banks)
//   rd_en_a/b, rd_addr    RAM read controls (address shared by both banks)
//   out_sel               downstream mux select: 0 = q_A, 1 = q_B
//   out_valid/out_ready   downstream bit handshake, out_last marks the last bit of a block
//   bank_full             [0] bank A full, [1] bank B full
//   ovf_cnt               (PPB_OVERFLOW_CNT_EN only) saturating count of cycles with in_valid && !in_ready
//
// Optional feature macro: PPB_OVERFLOW_CNT_EN
module pp_buffer_scheduler #(
    parameter int BLOCK_LEN = 192,
    parameter int ADDR_W    = $clog2(BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en_a,
    output logic              rd_en_b,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef PPB_OVERFLOW_CNT_EN
    output logic [15:0]       ovf_cnt,
`endif
    output logic [1:0]        bank_full
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_LEN - 1);

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic              wb;        // bank currently being written
    logic              rb;        // bank currently being read
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              accept;
    logic              wr_done;
    logic              issue;
    logic              rd_done;

    // Write side is purely combinational from registered state.
    assign in_ready  = !full[wb];
    assign accept    = in_valid & in_ready;
    assign wr_done   = accept & (wa == LAST_ADDR);
    assign wr_en_a   = accept & (wb == 1'b0);
    assign wr_en_b   = accept & (wb == 1'b1);
    assign wr_addr   = wa;
    assign rd_addr   = ra;
    assign bank_full = full;

    // Read FSM next state and read strobes.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        rd_done   = 1'b0;
        rd_en_a   = 1'b0;
        rd_en_b   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rb]) begin
                    state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                // A new read may go out whenever the output register is empty or draining.
                issue   = !out_valid | out_ready;
                rd_done = issue & (ra == LAST_ADDR);
                rd_en_a = issue & (rb == 1'b0);
                rd_en_b = issue & (rb == 1'b1);
                if (rd_done) begin
                    // Chain straight into the other bank if it is full now or completes this very cycle,
                    // so back-to-back blocks stream without an idle cycle.
                    if (full[~rb] | (wr_done & (wb != rb))) begin
                        state_nxt = RD_BURST;
                    end else begin
                        state_nxt = RD_IDLE;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Set and clear never target the same bank: a write needs !full, a read needs full.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb   <= 1'b0;
            rb   <= 1'b0;
            wa   <= '0;
            ra   <= '0;
            full <= 2'b00;
        end else begin
            full <= full_nxt;
            if (accept) begin
                if (wr_done) begin
                    wa <= '0;
                    wb <= ~wb;
                end else begin
                    wa <= wa + ADDR_W'(1);
                end
            end
            if (issue) begin
                if (rd_done) begin
                    ra <= '0;
                    rb <= ~rb;
                end else begin
                    ra <= ra + ADDR_W'(1);
                end
            end
        end
    end

    // Output qualifier tracks the one-cycle RAM read latency; a stalled bit holds because
    // the RAMs keep q while their read enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_sel   <= rb;
            out_last  <= (ra == LAST_ADDR);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef PPB_OVERFLOW_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt <= 16'h0000;
        end else if (in_valid && !in_ready && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pp_buffer_scheduler.sv
// Purpose : directed self-checking bench for pp_buffer_scheduler with behavioural 1-bit RAM banks.
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpress: scenarios cover full-rate streaming, held-off reads and random output stalls.
module tb_pp_buffer_scheduler;

    localparam int BL = 192;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en_a;
    logic          wr_en_b;
    logic [AW-1:0] wr_addr;
    logic          rd_en_a;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr;
    logic          out_sel;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [1:0]    bank_full;
`ifdef PPB_OVERFLOW_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    always #5 clk = ~clk;

    pp_buffer_scheduler #(.BLOCK_LEN(BL), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en_a   (wr_en_a),
        .wr_en_b   (wr_en_b),
        .wr_addr   (wr_addr),
        .rd_en_a   (rd_en_a),
        .rd_en_b   (rd_en_b),
        .rd_addr   (rd_addr),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef PPB_OVERFLOW_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .bank_full (bank_full)
    );

    // Behavioural RAM banks: synchronous write, registered read that holds when rd_en is low.
    logic in_data;
    logic mem_a [0:255];
    logic mem_b [0:255];
    logic q_a;
    logic q_b;
    always @(posedge clk) begin
        if (wr_en_a) mem_a[wr_addr] <= in_data;
        if (wr_en_b) mem_b[wr_addr] <= in_data;
        if (rd_en_a) q_a <= mem_a[rd_addr];
        if (rd_en_b) q_b <= mem_b[rd_addr];
    end

    int   checks = 0;
    int   errors = 0;
    logic sent_q [$];
    logic got_q  [$];
    int   last_pos [$];
    logic bit_out;

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sent_q.delete();
        got_q.delete();
        last_pos.delete();
    endtask

    // One clock cycle: drive, settle, record accepted and delivered bits.
    task automatic tick(input logic iv, input logic orr);
        @(negedge clk);
        in_valid  = iv;
        out_ready = orr;
        in_data   = 1'($urandom_range(0, 1));
        #1;
        bit_out = out_sel ? q_b : q_a;
        if (in_valid && in_ready) sent_q.push_back(in_data);
        if (out_valid && out_ready) begin
            got_q.push_back(bit_out);
            if (out_last) last_pos.push_back(got_q.size() - 1);
        end
    endtask

    function automatic int data_bad();
        int b = 0;
        if (got_q.size() != sent_q.size()) return -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== sent_q[i]) b++;
        return b;
    endfunction

    task automatic test_reset();
        logic [AW-1:0] pre;
        do_reset();
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        pre = wr_addr;
        checks++;
        if (pre !== 8'd50) begin errors++; $display("FAIL rst_pre_wa got %0d want 50", pre); end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++;
        if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full got %b want 00", bank_full); end
        checks++;
        if ({out_valid, out_last, out_sel} !== 3'b000) begin
            errors++; $display("FAIL rst_out got v/l/s %b want 000", {out_valid, out_last, out_sel});
        end
        checks++;
        if ({wr_addr, rd_addr} !== 16'h0000) begin
            errors++; $display("FAIL rst_addr got wr %0d rd %0d want 0 0", wr_addr, rd_addr);
        end
        checks++;
        if ({wr_en_a, wr_en_b, rd_en_a, rd_en_b} !== 4'b0000) begin
            errors++; $display("FAIL rst_en got %b want 0000", {wr_en_a, wr_en_b, rd_en_a, rd_en_b});
        end
`ifdef PPB_OVERFLOW_CNT_EN
        checks++;
        if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovf got %0d want 0", ovf_cnt); end
`endif
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 1'b1);
        checks++;
        if (!(wr_en_a === 1'b1 && wr_addr === 8'd0)) begin
            errors++; $display("FAIL rst_restart got wr_en_a %b addr %0d want 1 0", wr_en_a, wr_addr);
        end
    endtask

    task automatic test_back_to_back();
        int wa_bad = 0, wb_bad = 0, rda_bad = 0, early_rd = 0, first_ov = -1, last_a = -1;
        logic conc = 1'b0;
        logic [1:0] bf192 = 2'bxx;
        logic lp_ok;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick(i < 384, 1'b1);
            if (i < 192) begin
                if (!(wr_en_a && !wr_en_b && wr_addr == AW'(i))) wa_bad++;
            end else if (i < 384) begin
                if (!(wr_en_b && !wr_en_a && wr_addr == AW'(i - 192))) wb_bad++;
            end
            if (i == 192) bf192 = bank_full;
            if (i < 193 && (rd_en_a || rd_en_b)) early_rd++;
            if (i >= 193 && i < 385 && !(rd_en_a && !rd_en_b && rd_addr == AW'(i - 193))) rda_bad++;
            if (i == 300) conc = wr_en_b & rd_en_a;
            if (out_valid && first_ov < 0) first_ov = i;
            if (out_valid && out_last && !out_sel && last_a < 0) last_a = i;
        end
        checks++;
        if (wa_bad != 0) begin errors++; $display("FAIL b2b_wr_a bad cycles %0d want 0", wa_bad); end
        checks++;
        if (wb_bad != 0) begin errors++; $display("FAIL b2b_wr_b bad cycles %0d want 0", wb_bad); end
        checks++;
        if (bf192 !== 2'b01) begin errors++; $display("FAIL b2b_full_a got %b want 01", bf192); end
        checks++;
        if (early_rd != 0) begin errors++; $display("FAIL b2b_early_rd got %0d want 0", early_rd); end
        checks++;
        if (rda_bad != 0) begin errors++; $display("FAIL b2b_rd_a bad cycles %0d want 0", rda_bad); end
        checks++;
        if (conc !== 1'b1) begin errors++; $display("FAIL b2b_concurrent got %b want 1", conc); end
        checks++;
        if (first_ov != 194) begin errors++; $display("FAIL b2b_first_ov got %0d want 194", first_ov); end
        checks++;
        if (last_a != 385) begin errors++; $display("FAIL b2b_last_a got %0d want 385", last_a); end
        checks++;
        if (data_bad() != 0 || got_q.size() != 384) begin
            errors++; $display("FAIL b2b_data bad %0d count %0d want 0 384", data_bad(), got_q.size());
        end
        lp_ok = (last_pos.size() == 2) && (last_pos[0] == 191) && (last_pos[1] == 383);
        checks++;
        if (!lp_ok) begin errors++; $display("FAIL b2b_last_pos count %0d want 2 at 191,383", last_pos.size()); end
        checks++;
        if ({bank_full, in_ready} !== 3'b001) begin
            errors++; $display("FAIL b2b_final full %b ready %b want 00 1", bank_full, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int wr_stall = 0, rd_stall = 0;
        logic [1:0] bf384 = 2'bxx;
        logic ir384 = 1'bx, r585 = 1'b0, ir586 = 1'bx;
`ifdef PPB_OVERFLOW_CNT_EN
        logic [15:0] ov394 = 16'hxxxx;
`endif
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick(i < 394, i >= 395);
            if (i == 384) begin bf384 = bank_full; ir384 = in_ready; end
            if (i >= 384 && i < 394 && (wr_en_a || wr_en_b)) wr_stall++;
            if (i >= 194 && i < 395 && (rd_en_a || rd_en_b)) rd_stall++;
            if (i == 585) r585 = rd_en_a && (rd_addr == 8'd191) && !in_ready;
            if (i == 586) ir586 = in_ready;
`ifdef PPB_OVERFLOW_CNT_EN
            if (i == 394) ov394 = ovf_cnt;
`endif
        end
        checks++;
        if (bf384 !== 2'b11) begin errors++; $display("FAIL bp_both_full got %b want 11", bf384); end
        checks++;
        if (ir384 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got %b want 0", ir384); end
        checks++;
        if (wr_stall != 0) begin errors++; $display("FAIL bp_wr_while_full got %0d want 0", wr_stall); end
        checks++;
        if (rd_stall != 0) begin errors++; $display("FAIL bp_rd_while_stalled got %0d want 0", rd_stall); end
        checks++;
        if (r585 !== 1'b1) begin errors++; $display("FAIL bp_last_rd_a got %b want 1", r585); end
        checks++;
        if (ir586 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %b want 1", ir586); end
        checks++;
        if (data_bad() != 0 || got_q.size() != 384) begin
            errors++; $display("FAIL bp_data bad %0d count %0d want 0 384", data_bad(), got_q.size());
        end
`ifdef PPB_OVERFLOW_CNT_EN
        checks++;
        if (ov394 !== 16'd10) begin errors++; $display("FAIL ovf_cnt got %0d want 10", ov394); end
`endif
    endtask

    task automatic test_random_stall();
        int guard = 0, hold_bad = 0, rd_bad = 0;
        logic stall_prev = 1'b0, pb = 1'b0, pl = 1'b0, lp_ok;
        do_reset();
        while (got_q.size() < 576 && guard < 6000) begin
            tick(sent_q.size() < 576, $urandom_range(0, 3) != 0);
            if (stall_prev && !(out_valid && bit_out === pb && out_last === pl)) hold_bad++;
            if (out_valid && !out_ready && (rd_en_a || rd_en_b)) rd_bad++;
            stall_prev = out_valid && !out_ready;
            pb = bit_out;
            pl = out_last;
            guard++;
        end
        checks++;
        if (guard >= 6000) begin errors++; $display("FAIL rs_timeout got %0d bits want 576", got_q.size()); end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL rs_hold bad cycles %0d want 0", hold_bad); end
        checks++;
        if (rd_bad != 0) begin errors++; $display("FAIL rs_rd_while_stalled got %0d want 0", rd_bad); end
        checks++;
        if (data_bad() != 0) begin errors++; $display("FAIL rs_data bad %0d want 0", data_bad()); end
        lp_ok = (last_pos.size() == 3) && (last_pos[0] == 191) && (last_pos[1] == 383) && (last_pos[2] == 575);
        checks++;
        if (!lp_ok) begin errors++; $display("FAIL rs_last_pos count %0d want 3 at 191,383,575", last_pos.size()); end
    endtask

    task automatic test_stream();
        int total = 200 * BL;
        int guard = 0, stalls = 0, stall_cyc = -1, first_ov = -1, bubbles = 0;
        do_reset();
        while (got_q.size() < total && guard < total + 2000) begin
            tick(sent_q.size() < total, 1'b1);
            if (in_valid && !in_ready) begin stalls++; stall_cyc = guard; end
            if (first_ov >= 0 && !out_valid) bubbles++;
            if (out_valid && first_ov < 0) first_ov = guard;
            guard++;
        end
        checks++;
        if (guard >= total + 2000) begin errors++; $display("FAIL st_timeout got %0d bits want %0d", got_q.size(), total); end
        // Only the very first block pair sees a one-cycle hold-off while bank A drains.
        checks++;
        if (stalls != 1 || stall_cyc != 384) begin
            errors++; $display("FAIL st_in_ready got %0d lows at %0d want 1 at 384", stalls, stall_cyc);
        end
        checks++;
        if (first_ov != 194) begin errors++; $display("FAIL st_first_ov got %0d want 194", first_ov); end
        checks++;
        if (bubbles != 0) begin errors++; $display("FAIL st_bubbles got %0d want 0", bubbles); end
        checks++;
        if (data_bad() != 0) begin errors++; $display("FAIL st_data bad %0d want 0", data_bad()); end
        checks++;
        if (last_pos.size() != 200) begin errors++; $display("FAIL st_lasts got %0d want 200", last_pos.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
